model_tensor_stream_sequencer: RTL and testbench

//  Generic multi-mode tensor streamer feeding controller data ports (W_IN/K_IN/U_IN/X_IN ...).

---
 rtl/model_tensor_stream_pkg.sv | 20 ++
 rtl/model_tensor_stream_fifo.sv | 60 ++++++
 rtl/model_tensor_stream_sequencer.sv | 269 ++++++++++++++++++++++++++
 tb/tb_model_tensor_stream_sequencer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/model_tensor_stream_pkg.sv
// Shared types for the tensor stream sequencer: loop-mode and FSM state encodings.
package model_tensor_stream_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_1D      = 2'd0,
    MODE_2D      = 2'd1,
    MODE_3D      = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_STREAM = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

endpackage

// File: rtl/model_tensor_stream_fifo.sv
// Synchronous FIFO buffering the sequencer's input stream.
// Ports:
//   clk_i, rst_ni   clock, asynchronous active-low reset
//   clr_i           synchronous flush of both pointers
//   wr_i, wdata_i   push (ignored when full)
//   rd_i            pop (ignored when empty)
//   head_o          element at the read pointer (valid when !empty_o)
//   full_o, empty_o occupancy flags
// DEPTH must be a power of two; pointers carry one extra wrap bit.
module model_tensor_stream_fifo #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          wr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          rd_i,
  output logic [DW-1:0] head_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wptr_q, rptr_q;
  logic          do_wr, do_rd;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign head_o  = mem_q[rptr_q[AW-1:0]];
  assign do_wr   = wr_i && !full_o;
  assign do_rd   = rd_i && !empty_o;

  // Pointer update
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else if (clr_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_wr) wptr_q <= wptr_q + (AW+1)'(1);
      if (do_rd) rptr_q <= rptr_q + (AW+1)'(1);
    end
  end

  // Storage
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_wr) begin
      mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

endmodule

// File: rtl/model_tensor_stream_sequencer.sv
// Tensor stream sequencer: buffers a valid/ready element stream and replays it with
// I/L/K loop enables in 1D (k), 2D (l,k) or 3D (i,l,k) order.
// Ports:
//   CLK, RST                      clock, asynchronous active-low reset
//   START, MODE, SIZE_{I,L,K}_IN  configuration, latched when idle
//   READY, ERROR                  completion / illegal-config pulses
//   DATA_IN, DATA_IN_VALID/READY  producer side
//   DATA_OUT, DATA_OUT_VALID/READY, I/L/K_ENABLE  consumer side
//   STALL_COUNT                   consumer stall cycles (MODEL_TENSOR_STREAM_STATUS_EN only)
// Build option: define MODEL_TENSOR_STREAM_STATUS_EN to add the STALL_COUNT status port.
module model_tensor_stream_sequencer
  import model_tensor_stream_pkg::*;
#(
  parameter int unsigned DATA_SIZE    = 64,
  parameter int unsigned CONTROL_SIZE = 64,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  output logic                    ERROR,
  input  logic [MODE_W-1:0]       MODE,
  input  logic [CONTROL_SIZE-1:0] SIZE_I_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_L_IN,
  input  logic [CONTROL_SIZE-1:0] SIZE_K_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  input  logic                    DATA_IN_VALID,
  output logic                    DATA_IN_READY,
  output logic [DATA_SIZE-1:0]    DATA_OUT,
  output logic                    DATA_OUT_VALID,
  input  logic                    DATA_OUT_READY,
  output logic                    I_ENABLE,
  output logic                    L_ENABLE,
  output logic                    K_ENABLE
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
  ,
  output logic [CONTROL_SIZE-1:0] STALL_COUNT
`endif
);

  localparam int unsigned CW = CONTROL_SIZE;
  localparam int unsigned PW = 3 * CONTROL_SIZE;

  state_e              state_q, state_d;
  mode_e               mode_q, mode_d;
  logic [CW-1:0]       size_i_q, size_i_d, size_l_q, size_l_d, size_k_q, size_k_d;
  logic [CW-1:0]       total_q, total_d, acc_q, acc_d;
  logic [CW-1:0]       cnt_i_q, cnt_i_d, cnt_l_q, cnt_l_d, cnt_k_q, cnt_k_d;
  logic [DATA_SIZE-1:0] dout_q, dout_d;
  logic                dout_valid_q, dout_valid_d;
  logic                i_en_q, i_en_d, l_en_q, l_en_d;
  logic                ready_q, ready_d, error_q, error_d;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
  logic [CW-1:0]       stall_q, stall_d;
`endif

  logic [CW-1:0]       eff_i, eff_l, eff_k;
  logic [PW-1:0]       prod;
  logic                cfg_err;
  logic                xfer, k_wrap, l_wrap, i_wrap, last_xfer;
  logic                din_ready_c, fifo_wr, fifo_rd, fifo_clr, fifo_full, fifo_empty;
  logic [DATA_SIZE-1:0] fifo_head;

  model_tensor_stream_fifo #(
    .DW    (DATA_SIZE),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (CLK),
    .rst_ni  (RST),
    .clr_i   (fifo_clr),
    .wr_i    (fifo_wr),
    .wdata_i (DATA_IN),
    .rd_i    (fifo_rd),
    .head_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Effective extents: sizes of unused loop levels collapse to 1
  always_comb begin
    eff_i = size_i_q;
    eff_l = size_l_q;
    eff_k = size_k_q;
    case (mode_q)
      MODE_1D: begin
        eff_i = CW'(1);
        eff_l = CW'(1);
      end
      MODE_2D: eff_i = CW'(1);
      default: ;
    endcase
  end

  // Full-width product so that truncation into CONTROL_SIZE can be flagged
  assign prod    = PW'(eff_i) * PW'(eff_l) * PW'(eff_k);
  assign cfg_err = (mode_q == MODE_ILLEGAL) || (eff_i == '0) || (eff_l == '0) ||
                   (eff_k == '0) || (|prod[PW-1:CW]);

  assign din_ready_c = (state_q == ST_STREAM) && !fifo_full && (acc_q < total_q);
  assign fifo_wr     = DATA_IN_VALID && din_ready_c;

  assign xfer      = (state_q == ST_STREAM) && dout_valid_q && DATA_OUT_READY;
  assign k_wrap    = (cnt_k_q == size_k_q - CW'(1));
  assign l_wrap    = (cnt_l_q == size_l_q - CW'(1));
  assign i_wrap    = (cnt_i_q == size_i_q - CW'(1));
  assign last_xfer = xfer && k_wrap && l_wrap && i_wrap;

  // Next-state and output logic
  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    size_i_d     = size_i_q;
    size_l_d     = size_l_q;
    size_k_d     = size_k_q;
    total_d      = total_q;
    acc_d        = acc_q;
    cnt_i_d      = cnt_i_q;
    cnt_l_d      = cnt_l_q;
    cnt_k_d      = cnt_k_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    i_en_d       = i_en_q;
    l_en_d       = l_en_q;
    ready_d      = 1'b0;
    error_d      = 1'b0;
    fifo_rd      = 1'b0;
    fifo_clr     = 1'b0;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
    stall_d      = stall_q;
`endif

    // Loop counters describe the element sitting in the output register
    if (xfer) begin
      if (k_wrap) begin
        cnt_k_d = '0;
        if (l_wrap) begin
          cnt_l_d = '0;
          cnt_i_d = i_wrap ? '0 : cnt_i_q + CW'(1);
        end else begin
          cnt_l_d = cnt_l_q + CW'(1);
        end
      end else begin
        cnt_k_d = cnt_k_q + CW'(1);
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (START) begin
          mode_d   = mode_e'(MODE);
          size_i_d = SIZE_I_IN;
          size_l_d = SIZE_L_IN;
          size_k_d = SIZE_K_IN;
          state_d  = ST_LOAD;
        end
      end

      ST_LOAD: begin
        size_i_d = eff_i;
        size_l_d = eff_l;
        size_k_d = eff_k;
        total_d  = prod[CW-1:0];
        acc_d    = '0;
        cnt_i_d  = '0;
        cnt_l_d  = '0;
        cnt_k_d  = '0;
        fifo_clr = 1'b1;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
        stall_d  = '0;
`endif
        if (cfg_err) begin
          state_d = ST_DONE;
          ready_d = 1'b1;
          error_d = 1'b1;
        end else begin
          state_d = ST_STREAM;
        end
      end

      ST_STREAM: begin
        if (fifo_wr) acc_d = acc_q + CW'(1);
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
        if (dout_valid_q && !DATA_OUT_READY && (stall_q != '1)) stall_d = stall_q + CW'(1);
`endif
        if (last_xfer) begin
          state_d      = ST_DONE;
          ready_d      = 1'b1;
          dout_valid_d = 1'b0;
          i_en_d       = 1'b0;
          l_en_d       = 1'b0;
        end else if ((!dout_valid_q || DATA_OUT_READY) && !fifo_empty) begin
          // Enables are taken from the post-transfer position of the incoming element
          fifo_rd      = 1'b1;
          dout_d       = fifo_head;
          dout_valid_d = 1'b1;
          l_en_d       = (cnt_k_d == '0);
          i_en_d       = (cnt_k_d == '0) && (cnt_l_d == '0);
        end else if (xfer) begin
          dout_valid_d = 1'b0;
          i_en_d       = 1'b0;
          l_en_d       = 1'b0;
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_1D;
      size_i_q     <= '0;
      size_l_q     <= '0;
      size_k_q     <= '0;
      total_q      <= '0;
      acc_q        <= '0;
      cnt_i_q      <= '0;
      cnt_l_q      <= '0;
      cnt_k_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      i_en_q       <= 1'b0;
      l_en_q       <= 1'b0;
      ready_q      <= 1'b0;
      error_q      <= 1'b0;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
      stall_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      size_i_q     <= size_i_d;
      size_l_q     <= size_l_d;
      size_k_q     <= size_k_d;
      total_q      <= total_d;
      acc_q        <= acc_d;
      cnt_i_q      <= cnt_i_d;
      cnt_l_q      <= cnt_l_d;
      cnt_k_q      <= cnt_k_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      i_en_q       <= i_en_d;
      l_en_q       <= l_en_d;
      ready_q      <= ready_d;
      error_q      <= error_d;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
      stall_q      <= stall_d;
`endif
    end
  end

  assign READY          = ready_q;
  assign ERROR          = error_q;
  assign DATA_IN_READY  = din_ready_c;
  assign DATA_OUT       = dout_q;
  assign DATA_OUT_VALID = dout_valid_q;
  assign K_ENABLE       = dout_valid_q;
  assign I_ENABLE       = i_en_q;
  assign L_ENABLE       = l_en_q;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
  assign STALL_COUNT    = stall_q;
`endif

endmodule

// File: tb/tb_model_tensor_stream_sequencer.sv
// Directed bench for model_tensor_stream_sequencer. Inputs change and outputs are
// sampled on the falling clock edge. Covers the STALL_COUNT port when
// MODEL_TENSOR_STREAM_STATUS_EN is defined.
module tb_model_tensor_stream_sequencer;

  logic        CLK = 1'b0;
  logic        RST;
  logic        START;
  logic        READY, ERROR;
  logic [1:0]  MODE;
  logic [63:0] SIZE_I_IN, SIZE_L_IN, SIZE_K_IN;
  logic [63:0] DATA_IN;
  logic        DATA_IN_VALID, DATA_IN_READY;
  logic [63:0] DATA_OUT;
  logic        DATA_OUT_VALID, DATA_OUT_READY;
  logic        I_ENABLE, L_ENABLE, K_ENABLE;
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
  logic [63:0] STALL_COUNT;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  model_tensor_stream_sequencer #(
    .DATA_SIZE    (64),
    .CONTROL_SIZE (64),
    .FIFO_DEPTH   (4)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .START          (START),
    .READY          (READY),
    .ERROR          (ERROR),
    .MODE           (MODE),
    .SIZE_I_IN      (SIZE_I_IN),
    .SIZE_L_IN      (SIZE_L_IN),
    .SIZE_K_IN      (SIZE_K_IN),
    .DATA_IN        (DATA_IN),
    .DATA_IN_VALID  (DATA_IN_VALID),
    .DATA_IN_READY  (DATA_IN_READY),
    .DATA_OUT       (DATA_OUT),
    .DATA_OUT_VALID (DATA_OUT_VALID),
    .DATA_OUT_READY (DATA_OUT_READY),
    .I_ENABLE       (I_ENABLE),
    .L_ENABLE       (L_ENABLE),
    .K_ENABLE       (K_ENABLE)
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
    ,
    .STALL_COUNT    (STALL_COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, 64'(READY), 64'd0);
    chk({tag, "_error"}, 64'(ERROR), 64'd0);
    chk({tag, "_in_ready"}, 64'(DATA_IN_READY), 64'd0);
    chk({tag, "_out"}, DATA_OUT, 64'd0);
    chk({tag, "_out_valid"}, 64'(DATA_OUT_VALID), 64'd0);
    chk({tag, "_enables"}, 64'({I_ENABLE, L_ENABLE, K_ENABLE}), 64'd0);
  endtask

  task automatic start_cfg(input logic [1:0] m, input int si, input int sl, input int sk);
    @(negedge CLK);
    START = 1'b1; MODE = m;
    SIZE_I_IN = 64'(si); SIZE_L_IN = 64'(sl); SIZE_K_IN = 64'(sk);
    @(negedge CLK);
    START = 1'b0;
  endtask

  // Producer offers 1..n_prod; checks each output element against its loop position.
  // rdy_pat: 0 always ready, 1 toggling, 2 three stalls on the first valid cycles.
  task automatic run_stream(input int k_sz, input int l_sz, input int n_exp, input int n_prod,
                            input int rdy_pat, input int abort_at, input bit poke_start);
    int acc, xfer, cyc, cyc_last, cyc_acc1, stalls_left, kk, ll;
    bit done, seen_v;
    acc = 0; xfer = 0; cyc = 0; cyc_last = -10; cyc_acc1 = -10; stalls_left = 3;
    done = 1'b0; seen_v = 1'b0;
    DATA_OUT_READY = 1'b1;
    while (!done && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      DATA_IN       = 64'(acc + 1);
      DATA_IN_VALID = (acc < n_prod);
      case (rdy_pat)
        1: DATA_OUT_READY = ~DATA_OUT_READY;
        2: begin
          DATA_OUT_READY = !(DATA_OUT_VALID && stalls_left > 0);
          if (!DATA_OUT_READY) stalls_left--;
        end
        default: DATA_OUT_READY = 1'b1;
      endcase
      if (poke_start && cyc == 8) begin
        START = 1'b1; MODE = 2'd3; SIZE_K_IN = 64'd0;
      end else begin
        START = 1'b0;
      end
      #1;
      if (READY) begin
        done = 1'b1;
        chk("ready_after_last", 64'(cyc), 64'(cyc_last + 1));
        chk("transfers", 64'(xfer), 64'(n_exp));
        chk("accepted", 64'(acc), 64'(n_exp));
        chk("done_error", 64'(ERROR), 64'd0);
        chk("done_out_valid", 64'(DATA_OUT_VALID), 64'd0);
      end else if (DATA_OUT_VALID) begin
        if (!seen_v) begin
          seen_v = 1'b1;
          chk("latency", 64'(cyc), 64'(cyc_acc1 + 2));
        end
        kk = xfer % k_sz;
        ll = (xfer / k_sz) % l_sz;
        chk("data", DATA_OUT, 64'(xfer + 1));
        chk("k_en", 64'(K_ENABLE), 64'd1);
        chk("l_en", 64'(L_ENABLE), 64'(kk == 0));
        chk("i_en", 64'(I_ENABLE), 64'(kk == 0 && ll == 0));
        if (DATA_OUT_READY) begin
          xfer++;
          cyc_last = cyc;
        end
      end
      if (acc >= n_exp && !done) chk("in_ready_low", 64'(DATA_IN_READY), 64'd0);
      if (DATA_IN_VALID && DATA_IN_READY) begin
        if (acc == 0) cyc_acc1 = cyc;
        acc++;
      end
      if (abort_at > 0 && xfer == abort_at) break;
    end
    DATA_IN_VALID = 1'b0;
    if (abort_at == 0) chk("done_seen", 64'(done), 64'd1);
  endtask

  task automatic err_test(input string tag, input logic [1:0] m, input int si, input int sl,
                          input int sk);
    start_cfg(m, si, sl, sk);
    #1;
    chk({tag, "_load_ready"}, 64'(READY), 64'd0);
    chk({tag, "_load_in_ready"}, 64'(DATA_IN_READY), 64'd0);
    @(negedge CLK); #1;
    chk({tag, "_ready"}, 64'(READY), 64'd1);
    chk({tag, "_error"}, 64'(ERROR), 64'd1);
    chk({tag, "_in_ready"}, 64'(DATA_IN_READY), 64'd0);
    chk({tag, "_out_valid"}, 64'(DATA_OUT_VALID), 64'd0);
    @(negedge CLK); #1;
    chk({tag, "_ready_drop"}, 64'(READY), 64'd0);
    chk({tag, "_error_drop"}, 64'(ERROR), 64'd0);
    chk({tag, "_idle_in_ready"}, 64'(DATA_IN_READY), 64'd0);
  endtask

  initial begin
    RST = 1'b0; START = 1'b0; MODE = 2'd0;
    SIZE_I_IN = '0; SIZE_L_IN = '0; SIZE_K_IN = '0;
    DATA_IN = '0; DATA_IN_VALID = 1'b0; DATA_OUT_READY = 1'b0;
    #3;
    chk_all_zero("reset");
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    // 2D L=2 K=3, always-ready consumer
    start_cfg(2'd1, 7, 2, 3);
    run_stream(3, 2, 6, 6, 0, 0, 1'b0);

    // 3D I=2 L=2 K=2, toggling consumer, producer offers more than needed
    start_cfg(2'd2, 2, 2, 2);
    run_stream(2, 2, 8, 10, 1, 0, 1'b0);

    // 1D K=1 against a burst of 6
    start_cfg(2'd0, 5, 5, 1);
    run_stream(1, 1, 1, 6, 0, 0, 1'b0);

    // Illegal configurations
    err_test("mode3", 2'd3, 2, 2, 2);
    err_test("l_zero", 2'd1, 1, 0, 3);

    // Reset mid-stream, then a clean rerun
    start_cfg(2'd1, 1, 2, 3);
    run_stream(3, 2, 6, 6, 0, 3, 1'b0);
    RST = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge CLK);
    RST = 1'b1;
    start_cfg(2'd1, 1, 2, 3);
    run_stream(3, 2, 6, 6, 0, 0, 1'b0);

    // 2D 1x4 with three consumer stalls and a START issued mid-stream
    start_cfg(2'd1, 1, 1, 4);
    run_stream(4, 1, 4, 4, 2, 0, 1'b1);
`ifdef MODEL_TENSOR_STREAM_STATUS_EN
    chk("stall_count", STALL_COUNT, 64'd3);
    @(negedge CLK); #1;
    chk("stall_count_hold", STALL_COUNT, 64'd3);
`endif
    @(negedge CLK); #1;
    chk("idle_after_poke_ready", 64'(READY), 64'd0);
    chk("idle_after_poke_in_ready", 64'(DATA_IN_READY), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
